mem_arbiter: RTL and testbench

- Shares the single core-side RAM port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Each requester issues one-cycle request pulses. The arbiter buffers one outstanding request per requester, grants the memory port to one requester at a time, and routes the response back to that requester only.
- Sits between ifu/lsu and the RAM/bus bridge.
- One memory transaction is in flight at any time.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single core-side RAM port, one transaction in flight.
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_cen_i,
    input  logic [AW-1:0]     ifu_addr_i,
    input  logic [2:0]        ifu_size_i,
    output logic [DW-1:0]     ifu_rdata_o,
    output logic              ifu_valid_o,
    input  logic              lsu_cen_i,
    input  logic              lsu_wen_i,
    input  logic [AW-1:0]     lsu_addr_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [DW-1:0]     lsu_wdata_i,
    input  logic [DW/8-1:0]   lsu_wmask_i,
    output logic [DW-1:0]     lsu_rdata_o,
    output logic              lsu_valid_o,
    output logic              mem_cen_o,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [2:0]        mem_size_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [DW/8-1:0]   mem_wmask_o,
    input  logic [DW-1:0]     mem_rdata_i,
    input  logic              mem_valid_i
);

    // state  | meaning
    // IDLE   | no transaction in flight, arbitrate pending/incoming requests
    // GNT_IF | IFU owns the memory port, waiting for mem_valid_i
    // GNT_LS | LSU owns the memory port, waiting for mem_valid_i
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_pend_if;
    logic                r_pend_ls;
    logic [AW-1:0]       r_if_addr;
    logic [2:0]          r_if_size;
    logic                r_ls_wen;
    logic [AW-1:0]       r_ls_addr;
    logic [2:0]          r_ls_size;
    logic [DW-1:0]       r_ls_wdata;
    logic [DW/8-1:0]     r_ls_wmask;
    logic [DW-1:0]       r_ifu_rdata;
    logic [DW-1:0]       r_lsu_rdata;
    logic                r_mem_cen;
    logic                r_mem_wen;
    logic [AW-1:0]       r_mem_addr;
    logic [2:0]          r_mem_size;
    logic [DW-1:0]       r_mem_wdata;
    logic [DW/8-1:0]     r_mem_wmask;
`ifdef MEM_ARB_RR_EN
    logic                r_last_ls;
`endif

    logic                w_resp_if;
    logic                w_resp_ls;
    logic                w_cap_if;
    logic                w_cap_ls;
    logic                w_req_if;
    logic                w_req_ls;
    logic                w_pick_ls;
    logic                w_pick_if;
    logic [AW-1:0]       w_if_addr;
    logic [2:0]          w_if_size;
    logic                w_ls_wen;
    logic [AW-1:0]       w_ls_addr;
    logic [2:0]          w_ls_size;
    logic [DW-1:0]       w_ls_wdata;
    logic [DW/8-1:0]     w_ls_wmask;

    assign w_resp_if = (r_state == GNT_IF) && mem_valid_i;
    assign w_resp_ls = (r_state == GNT_LS) && mem_valid_i;

    // A request in the same cycle as its own response is accepted (set beats clear).
    assign w_cap_if = ifu_cen_i && (!r_pend_if || w_resp_if);
    assign w_cap_ls = lsu_cen_i && (!r_pend_ls || w_resp_ls);

    assign w_req_if = r_pend_if || ifu_cen_i;
    assign w_req_ls = r_pend_ls || lsu_cen_i;

`ifdef MEM_ARB_RR_EN
    assign w_pick_ls = w_req_ls && (!w_req_if || !r_last_ls);
`else
    assign w_pick_ls = w_req_ls;
`endif
    assign w_pick_if = w_req_if && !w_pick_ls;

    // Buffered request wins; otherwise bypass the same-cycle request.
    assign w_if_addr  = r_pend_if ? r_if_addr  : ifu_addr_i;
    assign w_if_size  = r_pend_if ? r_if_size  : ifu_size_i;
    assign w_ls_wen   = r_pend_ls ? r_ls_wen   : lsu_wen_i;
    assign w_ls_addr  = r_pend_ls ? r_ls_addr  : lsu_addr_i;
    assign w_ls_size  = r_pend_ls ? r_ls_size  : lsu_size_i;
    assign w_ls_wdata = r_pend_ls ? r_ls_wdata : lsu_wdata_i;
    assign w_ls_wmask = r_pend_ls ? r_ls_wmask : lsu_wmask_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pend_if   <= 1'b0;
            r_pend_ls   <= 1'b0;
            r_if_addr   <= '0;
            r_if_size   <= '0;
            r_ls_wen    <= 1'b0;
            r_ls_addr   <= '0;
            r_ls_size   <= '0;
            r_ls_wdata  <= '0;
            r_ls_wmask  <= '0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
            r_mem_cen   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_size  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_ls   <= 1'b0;
`endif
        end else begin
            if (w_cap_if) begin
                r_if_addr <= ifu_addr_i;
                r_if_size <= ifu_size_i;
            end
            if (w_cap_ls) begin
                r_ls_wen   <= lsu_wen_i;
                r_ls_addr  <= lsu_addr_i;
                r_ls_size  <= lsu_size_i;
                r_ls_wdata <= lsu_wdata_i;
                r_ls_wmask <= lsu_wmask_i;
            end
            r_pend_if <= w_cap_if || (r_pend_if && !w_resp_if);
            r_pend_ls <= w_cap_ls || (r_pend_ls && !w_resp_ls);

            if (w_resp_if) r_ifu_rdata <= mem_rdata_i;
            if (w_resp_ls) r_lsu_rdata <= mem_rdata_i;

            case (r_state)
                IDLE: begin
                    r_mem_cen <= 1'b0;
                    if (w_pick_ls) begin
                        r_state     <= GNT_LS;
                        r_mem_cen   <= 1'b1;
                        r_mem_wen   <= w_ls_wen;
                        r_mem_addr  <= w_ls_addr;
                        r_mem_size  <= w_ls_size;
                        r_mem_wdata <= w_ls_wdata;
                        r_mem_wmask <= w_ls_wmask;
`ifdef MEM_ARB_RR_EN
                        r_last_ls   <= 1'b1;
`endif
                    end else if (w_pick_if) begin
                        r_state     <= GNT_IF;
                        r_mem_cen   <= 1'b1;
                        r_mem_wen   <= 1'b0;
                        r_mem_addr  <= w_if_addr;
                        r_mem_size  <= w_if_size;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= '0;
`ifdef MEM_ARB_RR_EN
                        r_last_ls   <= 1'b0;
`endif
                    end
                end
                GNT_IF, GNT_LS: begin
                    r_mem_cen <= 1'b0;
                    if (mem_valid_i) r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_cen <= 1'b0;
                end
            endcase
        end
    end

    assign ifu_valid_o = w_resp_if;
    assign lsu_valid_o = w_resp_ls;
    assign ifu_rdata_o = w_resp_if ? mem_rdata_i : r_ifu_rdata;
    assign lsu_rdata_o = w_resp_ls ? mem_rdata_i : r_lsu_rdata;

    assign mem_cen_o   = r_mem_cen;
    assign mem_wen_o   = r_mem_wen;
    assign mem_addr_o  = r_mem_addr;
    assign mem_size_o  = r_mem_size;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wmask_o = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requests, ties, writes, back-to-back, spurious valid, reset.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ifu_cen_i;
    logic [AW-1:0]     ifu_addr_i;
    logic [2:0]        ifu_size_i;
    logic [DW-1:0]     ifu_rdata_o;
    logic              ifu_valid_o;
    logic              lsu_cen_i;
    logic              lsu_wen_i;
    logic [AW-1:0]     lsu_addr_i;
    logic [2:0]        lsu_size_i;
    logic [DW-1:0]     lsu_wdata_i;
    logic [DW/8-1:0]   lsu_wmask_i;
    logic [DW-1:0]     lsu_rdata_o;
    logic              lsu_valid_o;
    logic              mem_cen_o;
    logic              mem_wen_o;
    logic [AW-1:0]     mem_addr_o;
    logic [2:0]        mem_size_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW/8-1:0]   mem_wmask_o;
    logic [DW-1:0]     mem_rdata_i;
    logic              mem_valid_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic          rr_ifu_first;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] second_addr;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_cen_i   (ifu_cen_i),
        .ifu_addr_i  (ifu_addr_i),
        .ifu_size_i  (ifu_size_i),
        .ifu_rdata_o (ifu_rdata_o),
        .ifu_valid_o (ifu_valid_o),
        .lsu_cen_i   (lsu_cen_i),
        .lsu_wen_i   (lsu_wen_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_size_i  (lsu_size_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_wmask_i (lsu_wmask_i),
        .lsu_rdata_o (lsu_rdata_o),
        .lsu_valid_o (lsu_valid_o),
        .mem_cen_o   (mem_cen_o),
        .mem_wen_o   (mem_wen_o),
        .mem_addr_o  (mem_addr_o),
        .mem_size_o  (mem_size_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_valid_i (mem_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ifu_cen_i   = 1'b0;
        ifu_addr_i  = '0;
        ifu_size_i  = '0;
        lsu_cen_i   = 1'b0;
        lsu_wen_i   = 1'b0;
        lsu_addr_i  = '0;
        lsu_size_i  = '0;
        lsu_wdata_i = '0;
        lsu_wmask_i = '0;
        mem_rdata_i = '0;
        mem_valid_i = 1'b0;
        step();
        step();
        check_eq("rst_mem_cen",   {63'd0, mem_cen_o}, 64'd0);
        check_eq("rst_mem_addr",  mem_addr_o, 64'd0);
        check_eq("rst_ifu_valid", {63'd0, ifu_valid_o}, 64'd0);
        check_eq("rst_lsu_valid", {63'd0, lsu_valid_o}, 64'd0);
        check_eq("rst_ifu_rdata", ifu_rdata_o, 64'd0);
        rst_n = 1'b1;

        // IFU-only read
        ifu_cen_i = 1'b1; ifu_addr_i = 64'h8000_0000; ifu_size_i = 3'd2;
        settle();
        check_eq("if_c0_cen", {63'd0, mem_cen_o}, 64'd0);
        step();
        ifu_cen_i = 1'b0; ifu_addr_i = '0;
        settle();
        check_eq("if_c1_cen",  {63'd0, mem_cen_o}, 64'd1);
        check_eq("if_c1_addr", mem_addr_o, 64'h8000_0000);
        check_eq("if_c1_size", {61'd0, mem_size_o}, 64'd2);
        check_eq("if_c1_wen",  {63'd0, mem_wen_o}, 64'd0);
        step();
        check_eq("if_c2_cen",  {63'd0, mem_cen_o}, 64'd0);
        check_eq("if_c2_addr", mem_addr_o, 64'h8000_0000);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'h0000_0013_0000_0093;
        settle();
        check_eq("if_c3_valid",  {63'd0, ifu_valid_o}, 64'd1);
        check_eq("if_c3_rdata",  ifu_rdata_o, 64'h0000_0013_0000_0093);
        check_eq("if_c3_lvalid", {63'd0, lsu_valid_o}, 64'd0);
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;
        settle();
        check_eq("if_c4_valid", {63'd0, ifu_valid_o}, 64'd0);
        check_eq("if_c4_hold",  ifu_rdata_o, 64'h0000_0013_0000_0093);
        check_eq("if_c4_lrd",   lsu_rdata_o, 64'd0);

        // Tie after an IFU grant: LSU first in both arbitration modes
        ifu_cen_i = 1'b1; ifu_addr_i = 64'h8000_0004; ifu_size_i = 3'd2;
        lsu_cen_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 64'h8000_1000; lsu_size_i = 3'd3;
        step();
        ifu_cen_i = 1'b0; lsu_cen_i = 1'b0; ifu_addr_i = '0; lsu_addr_i = '0;
        settle();
        check_eq("tie_c1_cen",  {63'd0, mem_cen_o}, 64'd1);
        check_eq("tie_c1_addr", mem_addr_o, 64'h8000_1000);
        check_eq("tie_c1_wen",  {63'd0, mem_wen_o}, 64'd0);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
        settle();
        check_eq("tie_c2_lvalid", {63'd0, lsu_valid_o}, 64'd1);
        check_eq("tie_c2_lrdata", lsu_rdata_o, 64'h1111_2222_3333_4444);
        check_eq("tie_c2_ivalid", {63'd0, ifu_valid_o}, 64'd0);
        check_eq("tie_c2_ihold",  ifu_rdata_o, 64'h0000_0013_0000_0093);
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;
        settle();
        check_eq("tie_c3_cen", {63'd0, mem_cen_o}, 64'd0);
        step();
        check_eq("tie_c4_cen",  {63'd0, mem_cen_o}, 64'd1);
        check_eq("tie_c4_addr", mem_addr_o, 64'h8000_0004);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        check_eq("tie_c5_ivalid", {63'd0, ifu_valid_o}, 64'd1);
        check_eq("tie_c5_lvalid", {63'd0, lsu_valid_o}, 64'd0);
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;

        // LSU write; inputs scrambled after capture to prove the payload is buffered
        lsu_cen_i = 1'b1; lsu_wen_i = 1'b1; lsu_addr_i = 64'h8000_2000; lsu_size_i = 3'd3;
        lsu_wdata_i = 64'h0000_0000_DEAD_BEEF; lsu_wmask_i = 8'h0F;
        step();
        lsu_cen_i = 1'b0; lsu_wen_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        settle();
        check_eq("wr_c1_cen",   {63'd0, mem_cen_o}, 64'd1);
        check_eq("wr_c1_wen",   {63'd0, mem_wen_o}, 64'd1);
        check_eq("wr_c1_addr",  mem_addr_o, 64'h8000_2000);
        check_eq("wr_c1_wdata", mem_wdata_o, 64'h0000_0000_DEAD_BEEF);
        check_eq("wr_c1_wmask", {56'd0, mem_wmask_o}, 64'h0F);
        step();
        check_eq("wr_c2_cen",   {63'd0, mem_cen_o}, 64'd0);
        check_eq("wr_c2_wen",   {63'd0, mem_wen_o}, 64'd1);
        check_eq("wr_c2_wdata", mem_wdata_o, 64'h0000_0000_DEAD_BEEF);
        check_eq("wr_c2_wmask", {56'd0, mem_wmask_o}, 64'h0F);
        step();
        mem_valid_i = 1'b1;
        settle();
        check_eq("wr_c3_lvalid", {63'd0, lsu_valid_o}, 64'd1);
        check_eq("wr_c3_ivalid", {63'd0, ifu_valid_o}, 64'd0);
        step();
        mem_valid_i = 1'b0;

        // Tie after an LSU grant: round-robin picks IFU, fixed priority still LSU
`ifdef MEM_ARB_RR_EN
        rr_ifu_first = 1'b1;
`else
        rr_ifu_first = 1'b0;
`endif
        first_addr  = rr_ifu_first ? 64'h8000_0100 : 64'h8000_3000;
        second_addr = rr_ifu_first ? 64'h8000_3000 : 64'h8000_0100;
        ifu_cen_i = 1'b1; ifu_addr_i = 64'h8000_0100;
        lsu_cen_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 64'h8000_3000;
        step();
        ifu_cen_i = 1'b0; lsu_cen_i = 1'b0; ifu_addr_i = '0; lsu_addr_i = '0;
        settle();
        check_eq("tie2_first_addr", mem_addr_o, first_addr);
        check_eq("tie2_first_wen",  {63'd0, mem_wen_o}, 64'd0);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
        settle();
        check_eq("tie2_first_ivalid", {63'd0, ifu_valid_o}, {63'd0, rr_ifu_first});
        check_eq("tie2_first_lvalid", {63'd0, lsu_valid_o}, {63'd0, ~rr_ifu_first});
        step();
        mem_valid_i = 1'b0;
        step();
        check_eq("tie2_second_cen",  {63'd0, mem_cen_o}, 64'd1);
        check_eq("tie2_second_addr", mem_addr_o, second_addr);
        step();
        mem_valid_i = 1'b1;
        settle();
        check_eq("tie2_second_ivalid", {63'd0, ifu_valid_o}, {63'd0, ~rr_ifu_first});
        check_eq("tie2_second_lvalid", {63'd0, lsu_valid_o}, {63'd0, rr_ifu_first});
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;

        // Back-to-back: new IFU request in the cycle of its own response
        ifu_cen_i = 1'b1; ifu_addr_i = 64'h8000_0200;
        step();
        ifu_cen_i = 1'b0; ifu_addr_i = '0;
        settle();
        check_eq("b2b_c1_addr", mem_addr_o, 64'h8000_0200);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'h0000_0000_0000_0001;
        ifu_cen_i = 1'b1; ifu_addr_i = 64'h8000_0208;
        settle();
        check_eq("b2b_c2_ivalid", {63'd0, ifu_valid_o}, 64'd1);
        step();
        mem_valid_i = 1'b0; ifu_cen_i = 1'b0; ifu_addr_i = '0;
        settle();
        check_eq("b2b_c3_cen", {63'd0, mem_cen_o}, 64'd0);
        step();
        check_eq("b2b_c4_cen",  {63'd0, mem_cen_o}, 64'd1);
        check_eq("b2b_c4_addr", mem_addr_o, 64'h8000_0208);
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'h0000_0000_0000_0002;
        settle();
        check_eq("b2b_c5_ivalid", {63'd0, ifu_valid_o}, 64'd1);
        check_eq("b2b_c5_rdata",  ifu_rdata_o, 64'h0000_0000_0000_0002);
        step();
        mem_valid_i = 1'b0;

        // Spurious mem_valid_i in IDLE
        step();
        mem_valid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        check_eq("spur_ivalid", {63'd0, ifu_valid_o}, 64'd0);
        check_eq("spur_lvalid", {63'd0, lsu_valid_o}, 64'd0);
        check_eq("spur_ihold",  ifu_rdata_o, 64'h0000_0000_0000_0002);
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;

        // Reset while LSU holds the port, then a late response
        lsu_cen_i = 1'b1; lsu_wen_i = 1'b1; lsu_addr_i = 64'h8000_4000;
        lsu_wdata_i = 64'h1234; lsu_wmask_i = 8'hFF;
        step();
        lsu_cen_i = 1'b0; lsu_wen_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        settle();
        check_eq("rst2_pre_cen", {63'd0, mem_cen_o}, 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_valid_i = 1'b1; mem_rdata_i = 64'h9999;
        settle();
        check_eq("rst2_cen",    {63'd0, mem_cen_o}, 64'd0);
        check_eq("rst2_wen",    {63'd0, mem_wen_o}, 64'd0);
        check_eq("rst2_addr",   mem_addr_o, 64'd0);
        check_eq("rst2_wdata",  mem_wdata_o, 64'd0);
        check_eq("rst2_lrdata", lsu_rdata_o, 64'd0);
        check_eq("rst2_lvalid", {63'd0, lsu_valid_o}, 64'd0);
        check_eq("rst2_ivalid", {63'd0, ifu_valid_o}, 64'd0);
        step();
        mem_valid_i = 1'b0; mem_rdata_i = '0;
        step();
        check_eq("rst2_no_regrant", {63'd0, mem_cen_o}, 64'd0);
        step();
        check_eq("rst2_no_regrant2", {63'd0, mem_cen_o}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
